// File: rtl/mem_prog_sequencer_if.sv
// mem_prog_sequencer_if: CPU, UART-programmer and memory-port signals of the program/run sequencer
interface mem_prog_sequencer_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              start_pg;
    logic              upg_rst_o;
    logic              upg_wen_i;
    logic [ADDR_W:0]   upg_adr_i;
    logic [DATA_W-1:0] upg_dat_i;
    logic              upg_done_i;
    logic              cpu_rstn_o;
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              cpu_valid_o;
    logic              dmem_en_o;
    logic              dmem_we_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [DATA_W-1:0] dmem_wdata_o;
    logic [DATA_W-1:0] dmem_rdata_i;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [DATA_W-1:0] imem_wdata_o;
    logic              prog_busy_o;
    logic [15:0]       prog_cnt_o;
    logic              prog_err_o;

    modport master (
        input  start_pg, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
               cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, dmem_rdata_i,
        output upg_rst_o, cpu_rstn_o, cpu_rdata_o, cpu_valid_o,
               dmem_en_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
               imem_we_o, imem_addr_o, imem_wdata_o,
               prog_busy_o, prog_cnt_o, prog_err_o
    );

    modport slave (
        output start_pg, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
               cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, dmem_rdata_i,
        input  upg_rst_o, cpu_rstn_o, cpu_rdata_o, cpu_valid_o,
               dmem_en_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
               imem_we_o, imem_addr_o, imem_wdata_o,
               prog_busy_o, prog_cnt_o, prog_err_o
    );
endinterface

// File: rtl/mem_prog_sequencer.sv
// mem_prog_sequencer: hands imem/dmem between the CPU core and the UART boot-programmer and sequences their resets.
// Optional feature: define PROG_WDT_EN to abort a stalled download after WDT_CYC idle cycles (sets sticky prog_err_o).
module mem_prog_sequencer #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 32,
    parameter int RESTART_CYC = 16,
    parameter int WDT_CYC     = 2**20
) (
    input  logic                 clk,
    input  logic                 rstn,
    mem_prog_sequencer_if.master bus
);
    typedef enum logic [1:0] {ST_RESTART, ST_RUN, ST_DRAIN, ST_PROG} state_t;
    localparam int RC_W = $clog2(RESTART_CYC);

    state_t          r_state;
    logic [RC_W-1:0] r_rst_cnt;
    logic            r_pg_d;
    logic            r_done_d;
    logic            r_valid;
    logic            r_rd;
    logic [15:0]     r_cnt;
    logic            w_run;
    logic            w_prog;
    logic            w_pg_edge;
    logic            w_done_edge;
    logic            w_cpu_acc;
    logic            w_upg_d;
    logic            w_upg_i;
    logic            w_wdt_exp;

    assign w_run       = r_state == ST_RUN;
    assign w_prog      = r_state == ST_PROG;
    assign w_pg_edge   = bus.start_pg & ~r_pg_d;
    assign w_done_edge = bus.upg_done_i & ~r_done_d;
    assign w_cpu_acc   = w_run & bus.cpu_req_i;
    assign w_upg_d     = w_prog & bus.upg_wen_i & bus.upg_adr_i[ADDR_W];
    assign w_upg_i     = w_prog & bus.upg_wen_i & ~bus.upg_adr_i[ADDR_W];

    // The dmem port is owned by the CPU in RUN and by the programmer in PROG; both paths are same-cycle.
    assign bus.dmem_en_o    = w_cpu_acc | w_upg_d;
    assign bus.dmem_we_o    = w_prog ? w_upg_d : w_cpu_acc & bus.cpu_we_i;
    assign bus.dmem_addr_o  = w_prog ? bus.upg_adr_i[ADDR_W-1:0] : bus.cpu_addr_i;
    assign bus.dmem_wdata_o = w_prog ? bus.upg_dat_i : bus.cpu_wdata_i;
    assign bus.imem_we_o    = w_upg_i;
    assign bus.imem_addr_o  = bus.upg_adr_i[ADDR_W-1:0];
    assign bus.imem_wdata_o = bus.upg_dat_i;

    // The CPU stays out of reset through DRAIN so its last request can complete.
    assign bus.cpu_rstn_o  = w_run | (r_state == ST_DRAIN);
    assign bus.upg_rst_o   = ~w_prog;
    assign bus.prog_busy_o = (r_state == ST_DRAIN) | w_prog;
    assign bus.cpu_valid_o = r_valid;
    assign bus.cpu_rdata_o = r_rd ? bus.dmem_rdata_i : {DATA_W{1'b0}};
    assign bus.prog_cnt_o  = r_cnt;

    // Mode FSM with restart timer, start_pg/done edge detectors, CPU response tracking and write counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_RESTART;
            r_rst_cnt <= '0;
            r_pg_d    <= 1'b0;
            r_done_d  <= 1'b1;
            r_valid   <= 1'b0;
            r_rd      <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_pg_d  <= bus.start_pg;
            r_valid <= w_cpu_acc;
            r_rd    <= w_cpu_acc & ~bus.cpu_we_i;
            if ((w_upg_d | w_upg_i) && r_cnt != 16'hFFFF)
                r_cnt <= r_cnt + 16'd1;
            case (r_state)
                ST_RESTART: begin
                    r_rst_cnt <= r_rst_cnt + 1'b1;
                    if (r_rst_cnt == RC_W'(RESTART_CYC - 1)) begin
                        r_state   <= ST_RUN;
                        r_rst_cnt <= '0;
                    end
                end
                ST_RUN: if (w_pg_edge) r_state <= ST_DRAIN;
                ST_DRAIN: begin
                    r_state  <= ST_PROG;
                    r_cnt    <= '0;
                    r_done_d <= 1'b1;
                end
                ST_PROG: begin
                    r_done_d <= bus.upg_done_i;
                    if (w_done_edge | w_wdt_exp) r_state <= ST_RESTART;
                end
                default: r_state <= ST_RESTART;
            endcase
        end
    end

`ifdef PROG_WDT_EN
    localparam int WD_W = $clog2(WDT_CYC);
    logic [WD_W-1:0] r_idle;
    logic            r_armed;
    logic            r_err;

    assign w_wdt_exp      = w_prog & r_armed & ~bus.upg_wen_i & (r_idle == WD_W'(WDT_CYC - 1));
    assign bus.prog_err_o = r_err;

    // Idle watchdog: armed by the first write of a session, restarted by every write, cleared on DRAIN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idle  <= '0;
            r_armed <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == ST_DRAIN) begin
            r_idle  <= '0;
            r_armed <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_prog) begin
            if (bus.upg_wen_i) begin
                r_idle  <= '0;
                r_armed <= 1'b1;
            end else if (w_wdt_exp) begin
                r_idle  <= '0;
                r_armed <= 1'b0;
                r_err   <= 1'b1;
            end else if (r_armed) begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end
`else
    localparam int unused_wdt_cyc = WDT_CYC;
    assign w_wdt_exp      = 1'b0;
    assign bus.prog_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_mem_prog_sequencer.sv
// tb_mem_prog_sequencer: directed bench with a mode-level reference model checked every cycle
module tb_mem_prog_sequencer;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int RC = 16;
    localparam int WDT = 100;
    localparam int M_RESTART = 0;
    localparam int M_RUN = 1;
    localparam int M_DRAIN = 2;
    localparam int M_PROG = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int failures = 0;

    mem_prog_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    mem_prog_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RESTART_CYC(RC), .WDT_CYC(WDT)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Block-RAM stand-ins driven purely by the DUT's memory strobes.
    logic [DW-1:0] dmem [0:(1<<AW)-1];
    logic [DW-1:0] imem [0:(1<<AW)-1];
    logic [DW-1:0] dmem_q;
    always @(posedge clk) begin
        if (bus.dmem_en_o && bus.dmem_we_o) dmem[bus.dmem_addr_o] <= bus.dmem_wdata_o;
        if (bus.dmem_en_o && !bus.dmem_we_o) dmem_q <= dmem[bus.dmem_addr_o];
        if (bus.imem_we_o) imem[bus.imem_addr_o] <= bus.imem_wdata_o;
    end
    assign bus.dmem_rdata_i = dmem_q;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: which side owns the memories, how long the restart lasts, what the CPU should read back.
    int m_mode, m_left, m_cnt, m_idle;
    bit m_pg_prev, m_done_prev, m_valid, m_rd, m_err, m_armed;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_dmem [int];

    task automatic model_reset();
        m_mode = M_RESTART;
        m_left = RC;
        m_cnt = 0;
        m_pg_prev = 0;
        m_valid = 0;
        m_rd = 0;
        m_err = 0;
        m_armed = 0;
        m_idle = 0;
    endtask

    task automatic model_step();
        bit pg_rise = bus.start_pg && !m_pg_prev;
        bit done_rise = bus.upg_done_i && !m_done_prev;
        bit expired = 0;
        m_pg_prev = bus.start_pg;
        m_valid = (m_mode == M_RUN) && bus.cpu_req_i;
        m_rd = m_valid && !bus.cpu_we_i;
        if (m_valid && bus.cpu_we_i) m_dmem[int'(bus.cpu_addr_i)] = bus.cpu_wdata_i;
        if (m_rd) m_rdata = m_dmem[int'(bus.cpu_addr_i)];
        case (m_mode)
            M_RESTART: begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = M_RUN;
            end
            M_RUN: if (pg_rise) m_mode = M_DRAIN;
            M_DRAIN: begin
                m_mode = M_PROG;
                m_cnt = 0;
                m_err = 0;
                m_done_prev = 1;
                m_armed = 0;
                m_idle = 0;
            end
            default: begin
                if (bus.upg_wen_i) begin
                    if (bus.upg_adr_i[AW]) m_dmem[int'(bus.upg_adr_i[AW-1:0])] = bus.upg_dat_i;
                    if (m_cnt < 65535) m_cnt++;
                    m_armed = 1;
                    m_idle = 0;
                end else if (m_armed) begin
                    m_idle++;
                end
                m_done_prev = bus.upg_done_i;
`ifdef PROG_WDT_EN
                expired = m_idle == WDT;
                if (expired) m_err = 1;
`endif
                if (done_rise || expired) begin
                    m_mode = M_RESTART;
                    m_left = RC;
                end
            end
        endcase
    endtask

    task automatic compare();
        bit prog = m_mode == M_PROG;
        bit exp_den = (m_mode == M_RUN && bus.cpu_req_i) || (prog && bus.upg_wen_i && bus.upg_adr_i[AW]);
        bit exp_iwe = prog && bus.upg_wen_i && !bus.upg_adr_i[AW];
        check("cpu_rstn", bus.cpu_rstn_o, m_mode == M_RUN || m_mode == M_DRAIN);
        check("upg_rst", bus.upg_rst_o, !prog);
        check("busy", bus.prog_busy_o, prog || m_mode == M_DRAIN);
        check("dmem_en", bus.dmem_en_o, exp_den);
        if (exp_den) begin
            check("dmem_we", bus.dmem_we_o, prog ? 1'b1 : bus.cpu_we_i);
            check("dmem_addr", bus.dmem_addr_o, prog ? bus.upg_adr_i[AW-1:0] : bus.cpu_addr_i);
            check("dmem_wdata", bus.dmem_wdata_o, prog ? bus.upg_dat_i : bus.cpu_wdata_i);
        end
        check("imem_we", bus.imem_we_o, exp_iwe);
        if (exp_iwe) begin
            check("imem_addr", bus.imem_addr_o, bus.upg_adr_i[AW-1:0]);
            check("imem_wdata", bus.imem_wdata_o, bus.upg_dat_i);
        end
        check("valid", bus.cpu_valid_o, m_valid);
        if (m_rd) check("rdata", bus.cpu_rdata_o, m_rdata);
        check("prog_cnt", bus.prog_cnt_o, m_cnt);
        check("prog_err", bus.prog_err_o, m_err);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        compare();
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [AW:0]   wadr [3];
    logic [DW-1:0] wdat [3];
    logic [DW-1:0] pat  [3];

    initial begin
        wadr[0] = 15'h0000; wadr[1] = 15'h0001; wadr[2] = 15'h4002;
        wdat[0] = 32'h1111_0000; wdat[1] = 32'h2222_0001; wdat[2] = 32'h3333_0002;
        pat[0] = 32'h1234_5678; pat[1] = 32'hA5A5_5A5A; pat[2] = 32'h0F0F_F0F0;
        bus.start_pg = 0; bus.upg_wen_i = 0; bus.upg_adr_i = '0; bus.upg_dat_i = '0; bus.upg_done_i = 0;
        bus.cpu_req_i = 0; bus.cpu_we_i = 0; bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
        repeat (3) cyc();
        @(negedge clk);
        check("rst_cpu_rstn", bus.cpu_rstn_o, 0);
        check("rst_upg_rst", bus.upg_rst_o, 1);
        check("rst_rdata", bus.cpu_rdata_o, 0);
        check("rst_valid", bus.cpu_valid_o, 0);
        check("rst_cnt", bus.prog_cnt_o, 0);
        cyc();
        rstn = 1;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            @(negedge clk);
            if (i >= 15) check("restart_len", bus.cpu_rstn_o, i == 16);
        end
        // RUN: write then read address 5
        cyc(); bus.cpu_req_i = 1; bus.cpu_we_i = 1; bus.cpu_addr_i = 5; bus.cpu_wdata_i = 32'hDEADBEEF;
        cyc(); bus.cpu_we_i = 0;
        @(negedge clk);
        check("rd_en_same_cycle", bus.dmem_en_o, 1);
        cyc(); bus.cpu_req_i = 0;
        @(negedge clk);
        check("rd_valid", bus.cpu_valid_o, 1);
        check("rd_data", bus.cpu_rdata_o, 32'hDEADBEEF);
        // back-to-back writes then reads
        for (int i = 0; i < 3; i++) begin
            cyc(); bus.cpu_req_i = 1; bus.cpu_we_i = 1; bus.cpu_addr_i = AW'(7 + i); bus.cpu_wdata_i = pat[i];
        end
        for (int i = 0; i < 3; i++) begin
            cyc(); bus.cpu_we_i = 0; bus.cpu_addr_i = AW'(7 + i);
        end
        cyc(); bus.cpu_req_i = 0;
        @(negedge clk);
        check("b2b_last_rdata", bus.cpu_rdata_o, 32'h0F0F_F0F0);
        // read in the cycle start_pg rises, then requests in DRAIN/PROG
        cyc(); bus.start_pg = 1; bus.cpu_req_i = 1; bus.cpu_we_i = 0; bus.cpu_addr_i = 5;
        cyc(); bus.upg_done_i = 1; bus.cpu_addr_i = 7;
        @(negedge clk);
        check("drain_no_en", bus.dmem_en_o, 0);
        check("drain_valid", bus.cpu_valid_o, 1);
        check("drain_rdata", bus.cpu_rdata_o, 32'hDEADBEEF);
        check("drain_busy", bus.prog_busy_o, 1);
        cyc();
        @(negedge clk);
        check("prog_no_en", bus.dmem_en_o, 0);
        check("prog_valid", bus.cpu_valid_o, 0);
        check("prog_cpu_rstn", bus.cpu_rstn_o, 0);
        check("prog_upg_rst", bus.upg_rst_o, 0);
        // three programmer writes, done stale-high
        for (int i = 0; i < 3; i++) begin
            cyc(); bus.cpu_req_i = 0; bus.upg_wen_i = 1; bus.upg_adr_i = wadr[i]; bus.upg_dat_i = wdat[i];
            @(negedge clk);
            check("prog_imem_we", bus.imem_we_o, i < 2);
            check("prog_dmem_we", bus.dmem_en_o && bus.dmem_we_o, i == 2);
            cyc(); bus.upg_wen_i = 0;
        end
        cyc();
        @(negedge clk);
        check("prog_cnt3", bus.prog_cnt_o, 3);
        check("imem0", imem[0], 32'h1111_0000);
        check("imem1", imem[1], 32'h2222_0001);
        check("dmem2", dmem[2], 32'h3333_0002);
        check("stale_done_busy", bus.prog_busy_o, 1);
        cyc(); bus.start_pg = 0;
        cyc(); bus.start_pg = 1;
        cyc();
        @(negedge clk);
        check("pg_ignored_in_prog", bus.prog_busy_o, 1);
        // done falls, then rises together with a final write
        cyc(); bus.upg_done_i = 0;
        cyc(); bus.upg_done_i = 1; bus.upg_wen_i = 1; bus.upg_adr_i = 15'h0003; bus.upg_dat_i = 32'hCAFEF00D;
        @(negedge clk);
        check("final_imem_we", bus.imem_we_o, 1);
        cyc(); bus.upg_wen_i = 0;
        @(negedge clk);
        check("restart_cpu_rstn", bus.cpu_rstn_o, 0);
        check("restart_upg_rst", bus.upg_rst_o, 1);
        check("cnt_hold", bus.prog_cnt_o, 4);
        check("imem3", imem[3], 32'hCAFEF00D);
        for (int i = 1; i <= 16; i++) begin
            cyc();
            @(negedge clk);
            if (i >= 15) check("restart2_len", bus.cpu_rstn_o, i == 16);
        end
        // CPU reads back the programmed dmem word
        cyc(); bus.start_pg = 0; bus.cpu_req_i = 1; bus.cpu_we_i = 0; bus.cpu_addr_i = 2;
        cyc(); bus.cpu_req_i = 0;
        @(negedge clk);
        check("readback_prog", bus.cpu_rdata_o, 32'h3333_0002);
        // second session: counter clears, then saturates
        cyc(); bus.start_pg = 1;
        cyc();
        cyc();
        @(negedge clk);
        check("cnt_cleared", bus.prog_cnt_o, 0);
        cyc(); bus.upg_wen_i = 1; bus.upg_adr_i = 15'd100; bus.upg_dat_i = 32'h5555_AAAA;
        repeat (65536) cyc();
        bus.upg_wen_i = 0;
        @(negedge clk);
        check("cnt_sat", bus.prog_cnt_o, 16'hFFFF);
        // reset mid-PROG
        cyc(); bus.upg_wen_i = 1; bus.upg_adr_i = 15'h4004; bus.upg_dat_i = 32'h1;
        #2 rstn = 0;
        @(negedge clk);
        check("abort_cnt", bus.prog_cnt_o, 0);
        check("abort_cpu_rstn", bus.cpu_rstn_o, 0);
        check("abort_upg_rst", bus.upg_rst_o, 1);
        check("abort_imem_kept", imem[0], 32'h1111_0000);
        cyc(); bus.upg_wen_i = 0;
        cyc(); rstn = 1;
        repeat (16) cyc();
        @(negedge clk);
        check("rerun_cpu_rstn", bus.cpu_rstn_o, 1);
`ifdef PROG_WDT_EN
        cyc(); bus.start_pg = 0;
        cyc(); bus.start_pg = 1;
        cyc();
        cyc(); bus.upg_done_i = 1;
        cyc(); bus.upg_wen_i = 1; bus.upg_adr_i = 15'h0010; bus.upg_dat_i = 32'h77;
        cyc(); bus.upg_wen_i = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc();
            @(negedge clk);
            if (i >= 99) begin
                check("wdt_upg_rst", bus.upg_rst_o, i == 100);
                check("wdt_err", bus.prog_err_o, i == 100);
            end
        end
        repeat (16) cyc();
        cyc(); bus.start_pg = 0;
        cyc(); bus.start_pg = 1;
        cyc();
        cyc();
        @(negedge clk);
        check("wdt_err_cleared", bus.prog_err_o, 0);
        check("wdt_second_prog", bus.prog_busy_o, 1);
`endif
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
